main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 The ports SHALL be:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  Funct[5] I bit, Funct[4:1] cmd, Funct[0] S bit (L bit for memory).
- Rd  in  4  destination register number.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALU result.
- ALUSrcA  out  2  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ResultSrc  out  2  result bus select.
- ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- NextPC  out  1  unconditional PC update strobe.
- PCS  out  1  conditional PC write request to condlogic.
- RegW  out  1  register write request to condlogic.
- MemW  out  1  memory write request to condlogic.
- FlagW  out  2  flag write request: [1] N,Z; [0] C,V.
- State  out  4  current state encoding, for debug and verification.

Function
REQ-003 The state register SHALL hold one of ten states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-004 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR if Op=01.
- DECODE->EXECUTER if Op=00 and Funct[5]=0.
- DECODE->EXECUTEI if Op=00 and Funct[5]=1.
- DECODE->BRANCH if Op=10.
- DECODE->FETCH if Op=11.
- MEMADR->MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER->ALUWB and EXECUTEI->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-005 Any unused encoding (10-15) SHALL go to FETCH on the next edge with every write strobe at 0.
REQ-006 Outputs SHALL be Moore decodes of State; any signal not listed for a state is 0. Format is AdrSrc/ALUSrcA/ALUSrcB/ResultSrc:
- FETCH: 0/01/10/10; IRWrite=1, NextPC=1, ALUOp=0.
- DECODE: 0/01/10/10; ALUOp=0.
- MEMADR: 0/00/01/00; ALUOp=0.
- MEMREAD: 1/00/00/00.
- MEMWB: 0/00/00/01; RegW=1.
- MEMWRITE: 1/00/00/00; MemW=1.
- EXECUTER: 0/00/00/00; ALUOp=1.
- EXECUTEI: 0/00/01/00; ALUOp=1.
- ALUWB: 0/00/00/00; RegW=1.
- BRANCH: 0/00/01/10; ALUOp=0, Branch=1.
REQ-007 With ALUOp=0 (internal), ALUControl SHALL be 00 and FlagW SHALL be 00.
REQ-008 With ALUOp=1, ALUControl SHALL follow Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11; any other cmd gives 00.
REQ-009 With ALUOp=1 and a defined cmd, FlagW[1] SHALL equal Funct[0] and FlagW[0] SHALL equal Funct[0] AND (ALUControl is 00 or 01). An undefined cmd SHALL give FlagW=00.
REQ-010 PCS SHALL equal (RegW AND Rd=4'hF) OR Branch, combinationally, in the same cycle.
REQ-011 Instruction latencies from FETCH back to FETCH SHALL be: LDR 5 cycles, STR 4, data-processing 4, branch 3, undefined 2.
REQ-012 Op, Funct and Rd SHALL be sampled only through the current state; the block stores no copy of them.

Reset
REQ-013 While reset=0, State SHALL be FETCH asynchronously, independent of clk.
REQ-014 While reset=0, IRWrite, NextPC, RegW, MemW, PCS and FlagW SHALL be forced to 0; the select outputs SHALL show their FETCH values.
REQ-015 Reset asserted in any state, mid-instruction, SHALL abort that instruction with no write strobe asserted afterward.
REQ-016 On the first rising clk edge after reset rises, the block SHALL be in FETCH with IRWrite=1 and NextPC=1, and SHALL move to DECODE on the following edge.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Op=01, Funct=011001, Rd=4'h3 -> states 0,1,2,3,4,0; RegW=1 only in MEMWB; PCS=0.
- Op=01, Funct=011000 -> states 0,1,2,5,0; MemW=1 only in MEMWRITE; AdrSrc=1.
- Op=00, Funct=000101 (SUBS reg) -> in EXECUTER, ALUControl=01 and FlagW=11; in ALUWB, RegW=1.
- Op=00, Funct=111001 (ORRS imm), Rd=4'hF -> in EXECUTEI, ALUControl=11 and FlagW=10; in ALUWB, RegW=1 and PCS=1.
- Op=10 -> states 0,1,9,0; PCS=1 in BRANCH; Op=11 -> states 0,1,0 with no strobes.
- reset driven low mid-MEMWRITE, between clock edges -> State=0 immediately and MemW=0 at once; after release, FETCH then DECODE.

Source files
------------

// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM that sequences fetch, decode,
// memory, execute and branch steps and drives the datapath selects and write strobes.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       aluop;
    logic       branch;
  } ctrl_t;

  // FETCH select values with every strobe held low; shown while in reset
  localparam ctrl_t RESET_CTRL = '{irwrite: 1'b0, adrsrc: 1'b0, alusrca: 2'b01,
                                   alusrcb: 2'b10, resultsrc: 2'b10, nextpc: 1'b0,
                                   regw: 1'b0, memw: 1'b0, aluop: 1'b0, branch: 1'b0};

  state_t state;
  state_t state_nx;
  ctrl_t  ctrl;
  logic   started;
  logic   cmd_ok;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
        c.irwrite = 1'b1;  c.nextpc  = 1'b1;
      end
      DECODE: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      MEMADR:   c.alusrcb = 2'b01;
      MEMREAD:  c.adrsrc  = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01; c.regw = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc = 1'b1; c.memw = 1'b1;
      end
      EXECUTER: c.aluop = 1'b1;
      EXECUTEI: begin
        c.alusrcb = 2'b01; c.aluop = 1'b1;
      end
      ALUWB:    c.regw = 1'b1;
      BRANCH: begin
        c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:    state_nx = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_nx = MEMADR;
          2'b00:   state_nx = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR:   state_nx = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nx = MEMWB;
      EXECUTER: state_nx = ALUWB;
      EXECUTEI: state_nx = ALUWB;
      default:  state_nx = FETCH;
    endcase
  end

  // The first edge after reset release holds FETCH and raises its strobes, so the
  // fetch is always a full cycle with IRWrite/NextPC visible before moving on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      ctrl    <= RESET_CTRL;
      started <= 1'b0;
    end else if (!started) begin
      state   <= FETCH;
      ctrl    <= decode(FETCH);
      started <= 1'b1;
    end else begin
      state   <= state_nx;
      ctrl    <= decode(state_nx);
    end
  end

  // ALU operation and flag enables follow the live Funct field during execute states
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    cmd_ok     = 1'b0;
    if (ctrl.aluop) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; cmd_ok = 1'b1; end
        4'b0010: begin ALUControl = 2'b01; cmd_ok = 1'b1; end
        4'b0000: begin ALUControl = 2'b10; cmd_ok = 1'b1; end
        4'b1100: begin ALUControl = 2'b11; cmd_ok = 1'b1; end
        default: begin ALUControl = 2'b00; cmd_ok = 1'b0; end
      endcase
      if (cmd_ok) begin
        FlagW[1] = Funct[0];
        FlagW[0] = Funct[0] & ~ALUControl[1];
      end
    end
  end

  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign NextPC    = ctrl.nextpc;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign PCS       = (ctrl.regw & (Rd == 4'hF)) | ctrl.branch;
  assign State     = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: a driver pushes per-cycle expected outputs from an
// instruction-level model, and a negedge monitor pops and compares them.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic       IRWrite, AdrSrc, NextPC, PCS, RegW, MemW;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0] st;
    logic       ir;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [1:0] alu;
    logic       npc;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] fw;
  } outs_t;

  outs_t q[$];
  outs_t mon_e;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .NextPC(NextPC), .PCS(PCS),
    .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .State(State)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t a;
    a.st = State; a.ir = IRWrite; a.adr = AdrSrc; a.sa = ALUSrcA; a.sb = ALUSrcB;
    a.rs = ResultSrc; a.alu = ALUControl; a.npc = NextPC; a.pcs = PCS;
    a.regw = RegW; a.memw = MemW; a.fw = FlagW;
    return a;
  endfunction

  // Expected outputs for a given state number, straight from the output table
  function automatic outs_t model(input int s, input logic [5:0] f, input logic [3:0] rd);
    outs_t o;
    logic  aluop;
    logic  br;
    logic  def;
    o = '0; aluop = 1'b0; br = 1'b0; def = 1'b1;
    o.st = 4'(s);
    case (s)
      0: begin o.sa = 2'd1; o.sb = 2'd2; o.rs = 2'd2; o.ir = 1'b1; o.npc = 1'b1; end
      1: begin o.sa = 2'd1; o.sb = 2'd2; o.rs = 2'd2; end
      2: o.sb = 2'd1;
      3: o.adr = 1'b1;
      4: begin o.rs = 2'd1; o.regw = 1'b1; end
      5: begin o.adr = 1'b1; o.memw = 1'b1; end
      6: aluop = 1'b1;
      7: begin o.sb = 2'd1; aluop = 1'b1; end
      8: o.regw = 1'b1;
      9: begin o.sb = 2'd1; o.rs = 2'd2; br = 1'b1; end
      default: o = '0;
    endcase
    if (aluop) begin
      case (f[4:1])
        4'd4:    o.alu = 2'd0;
        4'd2:    o.alu = 2'd1;
        4'd0:    o.alu = 2'd2;
        4'd12:   o.alu = 2'd3;
        default: begin o.alu = 2'd0; def = 1'b0; end
      endcase
      if (def) o.fw = {f[0], f[0] && (o.alu < 2'd2)};
    end
    o.pcs = (o.regw && rd == 4'hF) || br;
    return o;
  endfunction

  function automatic outs_t rst_outs();
    outs_t o;
    o = model(0, 6'd0, 4'd0);
    o.ir = 1'b0;
    o.npc = 1'b0;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check($sformatf("cycle %0d state %0d", cyc, mon_e.st), sample(), mon_e);
    end
  end

  task automatic step(input logic rv, input logic [1:0] op, input logic [5:0] f,
                      input logic [3:0] rd, input outs_t e);
    @(posedge clk);
    #2;
    reset = rv; Op = op; Funct = f; Rd = rd;
    q.push_back(e);
  endtask

  // Instruction-level state path, by class, for the whole FETCH..FETCH round trip
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    int sl[$];
    case (op)
      2'b01:   sl = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b00:   sl = '{0, 1, f[5] ? 7 : 6, 8};
      2'b10:   sl = '{0, 1, 9};
      default: sl = '{0, 1};
    endcase
    foreach (sl[i]) step(1'b1, op, f, rd, model(sl[i], f, rd));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    int         cmds[4];
    cmds = '{4, 2, 0, 12};
    #1 reset = 1'b0;
    #1 check("initial reset", sample(), rst_outs());
    step(1'b0, 2'b00, 6'd0, 4'd0, rst_outs());
    step(1'b0, 2'b00, 6'd0, 4'd0, rst_outs());
    step(1'b1, 2'b00, 6'd0, 4'd0, rst_outs());

    applyStimulus(2'b01, 6'b011001, 4'h3);
    applyStimulus(2'b01, 6'b011000, 4'h2);
    applyStimulus(2'b00, 6'b000101, 4'h1);
    applyStimulus(2'b00, 6'b111001, 4'hF);
    applyStimulus(2'b10, 6'b000000, 4'h0);
    applyStimulus(2'b11, 6'b101010, 4'hF);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 1) == 1)
        f[4:1] = 4'(cmds[$urandom_range(0, 3)]);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      applyStimulus(op, f, rd);
    end

    // Abort a store in MEMWRITE with reset asserted between clock edges
    step(1'b1, 2'b01, 6'b011000, 4'h2, model(0, 6'b011000, 4'h2));
    step(1'b1, 2'b01, 6'b011000, 4'h2, model(1, 6'b011000, 4'h2));
    step(1'b1, 2'b01, 6'b011000, 4'h2, model(2, 6'b011000, 4'h2));
    step(1'b1, 2'b01, 6'b011000, 4'h2, model(5, 6'b011000, 4'h2));
    #5 reset = 1'b0;
    #1;
    check_val("async reset State", int'(State), 0);
    check_val("async reset MemW", int'(MemW), 0);
    check("async reset outputs", sample(), rst_outs());
    step(1'b0, 2'b01, 6'b011000, 4'h2, rst_outs());
    step(1'b0, 2'b01, 6'b011000, 4'h2, rst_outs());
    step(1'b1, 2'b01, 6'b011000, 4'h2, rst_outs());
    applyStimulus(2'b00, 6'b001000, 4'hF);
    applyStimulus(2'b01, 6'b011001, 4'hF);

    @(posedge clk);
    @(negedge clk);
    #1 check_val("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
